alu_dispatch: RTL and testbench

Issue-side partner of the ALU: accepts 32-bit LEGv8 instructions over a valid/ready handshake, decodes them into the 4-bit ALU control code, and fetches operands from the register file. It drives the ALU operand/opcode inputs, waits out the ALU's one-cycle registered latency, and retires the result as a register write, memory-address strobe or branch decision. It sits between fetch and the ALU/register file in the single-issue pipeline.

---
 rtl/alu_dispatch.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_alu_dispatch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch
//   Issue-side partner of the ALU. Accepts a 32-bit LEGv8 instruction over a
//   valid/ready handshake and decodes it into the 4-bit ALU control code. It
//   fetches operands from the register file and drives the ALU inputs. After
//   the ALU's one-cycle registered latency it retires the result as one of:
//   a register write, a memory-address strobe, a branch decision, or an
//   illegal-instruction strobe.
//
//   Optional feature macro: ALU_DISPATCH_ILLEGAL_TRAP_EN
//     defined   : an illegal instruction pulses `illegal`, then the block
//                 parks in HALT (halted=1, instr_ready=0) until reset.
//     undefined : `illegal` pulses, the instruction is dropped, and `halted`
//                 is tied low.
//
//   Ports
//     clock, reset_n              clock (rising edge), async active-low reset
//     instr_valid/instr_ready     fetch handshake; instr is the word
//     rf_raddr1/2, rf_rdata1/2    combinational register-file read port
//     rf_we, rf_waddr, rf_wdata   single-cycle register write
//     alu_in_one/two, alu_opcode  ALU operands and control code (registered)
//     alu_result                  registered ALU result
//     mem_addr_valid, mem_addr,   LDUR/STUR effective-address strobe;
//     mem_is_load                 mem_is_load is 1 for LDUR, 0 for STUR
//     branch_taken, branch_offset CBZ taken strobe and byte offset
//     illegal, halted             undecodable-instruction strobe, sticky halt
// ---------------------------------------------------------------------------
module alu_dispatch (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] alu_in_one,
    output logic [31:0] alu_in_two,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    output logic        mem_addr_valid,
    output logic [31:0] mem_addr,
    output logic        mem_is_load,
    output logic        branch_taken,
    output logic [31:0] branch_offset,
    output logic        illegal,
    output logic        halted
);

    localparam int DATA_W = 32;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] WB     = 3'd3;
`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
    localparam logic [2:0] HALT   = 3'd4;
`endif

    // Retire action chosen at decode time.
    localparam logic [1:0] KIND_REG = 2'd0;
    localparam logic [1:0] KIND_MEM = 2'd1;
    localparam logic [1:0] KIND_BR  = 2'd2;
    localparam logic [1:0] KIND_ILL = 2'd3;

    // Operand source selects.
    localparam logic [1:0] ONE_ZERO  = 2'd0;
    localparam logic [1:0] ONE_REG   = 2'd1;
    localparam logic [1:0] ONE_IMM16 = 2'd2;
    localparam logic [1:0] TWO_ZERO  = 2'd0;
    localparam logic [1:0] TWO_REG   = 2'd1;
    localparam logic [1:0] TWO_IMM9  = 2'd2;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_MOVZ = 11'b11010010100;   // hw field fixed at 0
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam logic [4:0]  XZR = 5'd31;

    function automatic logic signed [DATA_W-1:0] sextImm9(input logic [8:0] imm);
        return {{(DATA_W-9){imm[8]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zextImm16(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

    // Word offset to byte offset: sext(imm19) << 2.
    function automatic logic signed [DATA_W-1:0] branchOffset(input logic [18:0] imm);
        return {{(DATA_W-21){imm[18]}}, imm, 2'b00};
    endfunction

    logic [2:0]        state;
    logic [31:0]       instrP0;      // captured instruction
    logic [1:0]        kindP1;       // retire info latched at decode
    logic [4:0]        rdP1;
    logic              loadP1;
    logic [31:0]       offsetP1;

    logic [3:0]        decOp;
    logic [1:0]        decKind;
    logic              decLoad;
    logic [1:0]        decSrcOne;
    logic [1:0]        decSrcTwo;
    logic [31:0]       decOne;
    logic [31:0]       decTwo;
    logic [31:0]       readOne;
    logic [31:0]       readTwo;
    logic              handshake;

    // ---- decode of the captured instruction: addresses, opcode, sources
    always_comb begin
        decOp     = 4'b0000;
        decKind   = KIND_ILL;
        decLoad   = 1'b0;
        decSrcOne = ONE_ZERO;
        decSrcTwo = TWO_ZERO;
        rf_raddr1 = 5'd0;
        rf_raddr2 = 5'd0;
        case (instrP0[31:21])
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR: begin
                rf_raddr1 = instrP0[9:5];
                rf_raddr2 = instrP0[20:16];
                decSrcOne = ONE_REG;
                decSrcTwo = TWO_REG;
                decKind   = KIND_REG;
                case (instrP0[31:21])
                    OP_ADD:  decOp = 4'b0010;
                    OP_SUB:  decOp = 4'b1010;
                    OP_AND:  decOp = 4'b0110;
                    OP_ORR:  decOp = 4'b0100;
                    default: decOp = 4'b1001;
                endcase
            end
            OP_MOVZ: begin
                decOp     = 4'b1101;
                decSrcOne = ONE_IMM16;
                decKind   = KIND_REG;
            end
            OP_LDUR, OP_STUR: begin
                rf_raddr1 = instrP0[9:5];
                decOp     = 4'b0010;
                decSrcOne = ONE_REG;
                decSrcTwo = TWO_IMM9;
                decKind   = KIND_MEM;
                decLoad   = (instrP0[31:21] == OP_LDUR);
            end
            default: begin
                // CBZ decodes on a shorter 8-bit field, so it falls out of
                // the 11-bit match and is caught here.
                if (instrP0[31:24] == OP_CBZ) begin
                    rf_raddr1 = instrP0[4:0];
                    decOp     = 4'b0111;
                    decSrcOne = ONE_REG;
                    decKind   = KIND_BR;
                end
            end
        endcase
    end

    // XZR reads as zero regardless of what the register file returns.
    assign readOne = (rf_raddr1 == XZR) ? '0 : rf_rdata1;
    assign readTwo = (rf_raddr2 == XZR) ? '0 : rf_rdata2;

    always_comb begin
        decOne = '0;
        decTwo = '0;
        case (decSrcOne)
            ONE_REG:   decOne = readOne;
            ONE_IMM16: decOne = zextImm16(instrP0[20:5]);
            default:   decOne = '0;
        endcase
        case (decSrcTwo)
            TWO_REG:   decTwo = readTwo;
            TWO_IMM9:  decTwo = sextImm9(instrP0[20:12]);
            default:   decTwo = '0;
        endcase
    end

    // Ready in IDLE and WB; in WB of a trapping illegal instruction the
    // block is about to halt, so nothing new may be accepted.
    always_comb begin
        instr_ready = 1'b0;
        if (state == IDLE) begin
            instr_ready = 1'b1;
        end else if (state == WB) begin
`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
            instr_ready = (kindP1 != KIND_ILL);
`else
            instr_ready = 1'b1;
`endif
        end
    end

    assign handshake = instr_valid & instr_ready;

`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            instrP0        <= '0;
            kindP1         <= KIND_REG;
            rdP1           <= '0;
            loadP1         <= 1'b0;
            offsetP1       <= '0;
            alu_in_one     <= '0;
            alu_in_two     <= '0;
            alu_opcode     <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            mem_addr_valid <= 1'b0;
            mem_addr       <= '0;
            mem_is_load    <= 1'b0;
            branch_taken   <= 1'b0;
            branch_offset  <= '0;
            illegal        <= 1'b0;
        end else begin
            rf_we          <= 1'b0;
            mem_addr_valid <= 1'b0;
            branch_taken   <= 1'b0;
            illegal        <= 1'b0;
            case (state)
                // ---- capture
                IDLE: begin
                    if (handshake) begin
                        instrP0 <= instr;
                        state   <= DECODE;
                    end
                end
                // ---- decode: operands to ALU, retire info latched
                DECODE: begin
                    alu_in_one <= decOne;
                    alu_in_two <= decTwo;
                    alu_opcode <= decOp;
                    kindP1     <= decKind;
                    rdP1       <= instrP0[4:0];
                    loadP1     <= decLoad;
                    offsetP1   <= branchOffset(instrP0[23:5]);
                    state      <= EXEC;
                end
                // ---- ALU samples its inputs
                EXEC: begin
                    state <= WB;
                end
                // ---- retire; strobes appear in the following cycle
                WB: begin
                    case (kindP1)
                        KIND_REG: begin
                            if (rdP1 != XZR) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rdP1;
                                rf_wdata <= alu_result;
                            end
                        end
                        KIND_MEM: begin
                            mem_addr_valid <= 1'b1;
                            mem_addr       <= alu_result;
                            mem_is_load    <= loadP1;
                        end
                        KIND_BR: begin
                            branch_taken  <= alu_result[0];
                            branch_offset <= offsetP1;
                        end
                        default: begin
                            illegal <= 1'b1;
                        end
                    endcase
                    if (handshake) begin
                        instrP0 <= instr;
                        state   <= DECODE;
`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
                    end else if (kindP1 == KIND_ILL) begin
                        state <= HALT;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_dispatch
//   Directed bench for alu_dispatch. Surrounds the block with a small
//   register-file array and a registered ALU model, issues hand-encoded
//   LEGv8 instructions, and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_dispatch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_in_one, alu_in_two;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        mem_addr_valid;
    logic [31:0] mem_addr;
    logic        mem_is_load;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        illegal;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [31:0] regs [0:31];

    always #5 clock = ~clock;

    alu_dispatch dut (
        .clock(clock), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_in_one(alu_in_one), .alu_in_two(alu_in_two), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .mem_addr_valid(mem_addr_valid), .mem_addr(mem_addr), .mem_is_load(mem_is_load),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .illegal(illegal), .halted(halted)
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    // Registered ALU stand-in; 0111 reports a zero test of operand one.
    always_ff @(posedge clock) begin
        case (alu_opcode)
            4'b0010: alu_result <= alu_in_one + alu_in_two;
            4'b1010: alu_result <= alu_in_one - alu_in_two;
            4'b0110: alu_result <= alu_in_one & alu_in_two;
            4'b0100: alu_result <= alu_in_one | alu_in_two;
            4'b1001: alu_result <= alu_in_one ^ alu_in_two;
            4'b1101: alu_result <= alu_in_one;
            4'b0111: alu_result <= (alu_in_one == 32'd0) ? 32'd1 : 32'd0;
            default: alu_result <= 32'd0;
        endcase
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encR(input logic [10:0] op, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'b000000, rn, rd};
    endfunction

    function automatic logic [31:0] encD(input logic [10:0] op, input logic [8:0] imm9,
                                         input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm9, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] encCbz(input logic [18:0] imm19, input logic [4:0] rt);
        return {8'b10110100, imm19, rt};
    endfunction

    function automatic logic [31:0] encMovz(input logic [15:0] imm16, input logic [4:0] rd);
        return {11'b11010010100, imm16, rd};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers a word and returns #1 after the accepting edge (edge N).
    task automatic issue(input logic [31:0] w, input bit keepValid);
        bit done = 0;
        instr = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (instr_ready) done = 1;
            tick();
        end
        if (!keepValid) instr_valid = 1'b0;
        if (!done) checkEq("issue_timeout", 32'd0, 32'd1);
    endtask

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[31] = 32'hDEADBEEF;   // block must read XZR as 0 anyway

        // reset state
        #12;
        checkEq("rst_ready", {31'd0, instr_ready}, 32'd1);
        checkEq("rst_halted", {31'd0, halted}, 32'd0);
        checkEq("rst_opcode", {28'd0, alu_opcode}, 32'd0);
        checkEq("rst_in_one", alu_in_one, 32'd0);
        checkEq("rst_rf_we", {31'd0, rf_we}, 32'd0);
        checkEq("rst_branch_off", branch_offset, 32'd0);
        reset_n = 1'b1;
        tick();

        // ADD X3,X1,X2
        regs[1] = 32'd5; regs[2] = 32'd7;
        issue(encR(ADD, 5'd2, 5'd1, 5'd3), 0);
        checkEq("add_ready_decode", {31'd0, instr_ready}, 32'd0);
        tick();
        checkEq("add_opcode", {28'd0, alu_opcode}, 32'h2);
        checkEq("add_in_one", alu_in_one, 32'd5);
        checkEq("add_in_two", alu_in_two, 32'd7);
        tick();
        checkEq("add_no_early_we", {31'd0, rf_we}, 32'd0);
        checkEq("add_ready_wb", {31'd0, instr_ready}, 32'd1);
        tick();
        checkEq("add_rf_we", {31'd0, rf_we}, 32'd1);
        checkEq("add_waddr", {27'd0, rf_waddr}, 32'd3);
        checkEq("add_wdata", rf_wdata, 32'd12);
        tick();
        checkEq("add_we_single", {31'd0, rf_we}, 32'd0);
        checkEq("add_wdata_hold", rf_wdata, 32'd12);

        // SUB X4,X1,X2 wraps
        regs[1] = 32'd0; regs[2] = 32'd1;
        issue(encR(SUB, 5'd2, 5'd1, 5'd4), 0);
        tick();
        checkEq("sub_opcode", {28'd0, alu_opcode}, 32'hA);
        tick(); tick();
        checkEq("sub_rf_we", {31'd0, rf_we}, 32'd1);
        checkEq("sub_waddr", {27'd0, rf_waddr}, 32'd4);
        checkEq("sub_wdata", rf_wdata, 32'hFFFFFFFF);
        tick();

        // ADD X31 suppressed
        regs[1] = 32'd2; regs[2] = 32'd3;
        issue(encR(ADD, 5'd2, 5'd1, 5'd31), 0);
        tick(); tick(); tick();
        checkEq("xzr_we", {31'd0, rf_we}, 32'd0);
        checkEq("xzr_wdata_hold", rf_wdata, 32'hFFFFFFFF);
        tick();

        // ADD X7,X31,X2: XZR reads 0
        regs[2] = 32'd9;
        issue(encR(ADD, 5'd2, 5'd31, 5'd7), 0);
        tick();
        checkEq("xzr_read", alu_in_one, 32'd0);
        tick(); tick();
        checkEq("xzr_read_wdata", rf_wdata, 32'd9);
        tick();

        // LDUR X5,[X1,#-8]
        regs[1] = 32'h100;
        issue(encD(LDUR, 9'h1F8, 5'd1, 5'd5), 0);
        tick();
        checkEq("ldur_opcode", {28'd0, alu_opcode}, 32'h2);
        checkEq("ldur_in_one", alu_in_one, 32'h100);
        checkEq("ldur_in_two", alu_in_two, 32'hFFFFFFF8);
        tick(); tick();
        checkEq("ldur_valid", {31'd0, mem_addr_valid}, 32'd1);
        checkEq("ldur_addr", mem_addr, 32'hF8);
        checkEq("ldur_is_load", {31'd0, mem_is_load}, 32'd1);
        checkEq("ldur_no_we", {31'd0, rf_we}, 32'd0);
        tick();
        checkEq("ldur_valid_single", {31'd0, mem_addr_valid}, 32'd0);

        // STUR X5,[X1,#16]
        issue(encD(STUR, 9'd16, 5'd1, 5'd5), 0);
        tick(); tick(); tick();
        checkEq("stur_valid", {31'd0, mem_addr_valid}, 32'd1);
        checkEq("stur_addr", mem_addr, 32'h110);
        checkEq("stur_is_load", {31'd0, mem_is_load}, 32'd0);
        tick();

        // CBZ X6,+4 taken
        regs[6] = 32'd0;
        issue(encCbz(19'd4, 5'd6), 0);
        tick();
        checkEq("cbz_opcode", {28'd0, alu_opcode}, 32'h7);
        checkEq("cbz_in_two", alu_in_two, 32'd0);
        tick(); tick();
        checkEq("cbz_taken", {31'd0, branch_taken}, 32'd1);
        checkEq("cbz_offset", branch_offset, 32'd16);
        tick();
        checkEq("cbz_taken_single", {31'd0, branch_taken}, 32'd0);

        // CBZ X6,-1 not taken
        regs[6] = 32'd3;
        issue(encCbz(19'h7FFFF, 5'd6), 0);
        tick(); tick(); tick();
        checkEq("cbz_not_taken", {31'd0, branch_taken}, 32'd0);
        checkEq("cbz_neg_offset", branch_offset, 32'hFFFFFFFC);
        tick();

        // MOVZ X8,#0x1234
        issue(encMovz(16'h1234, 5'd8), 0);
        tick();
        checkEq("movz_opcode", {28'd0, alu_opcode}, 32'hD);
        checkEq("movz_in_one", alu_in_one, 32'h1234);
        tick(); tick();
        checkEq("movz_wdata", rf_wdata, 32'h1234);
        tick();

        // back-to-back ADDs
        regs[1] = 32'd10; regs[2] = 32'd20;
        issue(encR(ADD, 5'd2, 5'd1, 5'd9), 1);
        instr = encR(ADD, 5'd1, 5'd1, 5'd10);
        tick(); tick(); tick();
        instr_valid = 1'b0;
        checkEq("b2b_first_we", {31'd0, rf_we}, 32'd1);
        checkEq("b2b_first_wdata", rf_wdata, 32'd30);
        tick();
        checkEq("b2b_gap1", {31'd0, rf_we}, 32'd0);
        tick();
        checkEq("b2b_gap2", {31'd0, rf_we}, 32'd0);
        tick();
        checkEq("b2b_second_we", {31'd0, rf_we}, 32'd1);
        checkEq("b2b_second_waddr", {27'd0, rf_waddr}, 32'd10);
        checkEq("b2b_second_wdata", rf_wdata, 32'd20);
        tick();

        // reset during EXEC
        regs[1] = 32'd5; regs[2] = 32'd7;
        issue(encR(ADD, 5'd2, 5'd1, 5'd3), 0);
        tick();
        reset_n = 1'b0;
        #1;
        checkEq("arst_opcode", {28'd0, alu_opcode}, 32'd0);
        checkEq("arst_in_one", alu_in_one, 32'd0);
        checkEq("arst_wdata", rf_wdata, 32'd0);
        checkEq("arst_branch_off", branch_offset, 32'd0);
        checkEq("arst_ready", {31'd0, instr_ready}, 32'd1);
        #2;
        reset_n = 1'b1;
        begin
            logic anyStrobe = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                anyStrobe |= rf_we | mem_addr_valid | branch_taken | illegal;
            end
            checkEq("arst_no_strobe", {31'd0, anyStrobe}, 32'd0);
        end

        // illegal 0x00000000
        issue(32'h00000000, 0);
        tick();
        checkEq("ill_opcode", {28'd0, alu_opcode}, 32'd0);
        checkEq("ill_in_one", alu_in_one, 32'd0);
        tick(); tick();
        checkEq("ill_strobe", {31'd0, illegal}, 32'd1);
        checkEq("ill_no_we", {31'd0, rf_we}, 32'd0);
`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
        checkEq("ill_halted", {31'd0, halted}, 32'd1);
        checkEq("ill_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        checkEq("ill_single", {31'd0, illegal}, 32'd0);
        checkEq("ill_halted_sticky", {31'd0, halted}, 32'd1);
        checkEq("ill_ready_sticky", {31'd0, instr_ready}, 32'd0);
`else
        checkEq("ill_halted", {31'd0, halted}, 32'd0);
        checkEq("ill_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        checkEq("ill_single", {31'd0, illegal}, 32'd0);
        regs[1] = 32'd1; regs[2] = 32'd2;
        issue(encR(ADD, 5'd2, 5'd1, 5'd11), 0);
        tick(); tick(); tick();
        checkEq("post_ill_we", {31'd0, rf_we}, 32'd1);
        checkEq("post_ill_waddr", {27'd0, rf_waddr}, 32'd11);
        checkEq("post_ill_wdata", rf_wdata, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
